pg_port_ctrl: RTL and testbench

Per-router power-gating controller that consumes the per-port and per-router utilization counts produced by the load tracker and decides, once per epoch, which of the four mesh ports (E, W, N, S) are gated off. It produces the epoch-clear pulse and the per-port ACTIVE/INACTIVE status that the load tracker uses, so the two blocks form a closed loop. It also sequences each port through drain and wake-up, handshaking with the link and the neighbour router.

---
 rtl/pg_port_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pg_port_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pg_port_ctrl.sv
// pg_port_ctrl: per-router power-gating controller for the four mesh ports.
// Once per epoch it picks lightly loaded ports to gate off, then sequences each
// gated port through drain, power-off and wake-up, handshaking with the
// neighbour router.

`ifndef PG_PORT_LOAD_SIZE
`define PG_PORT_LOAD_SIZE 8
`endif
`ifndef PG_ROUTER_LOAD_SIZE
`define PG_ROUTER_LOAD_SIZE 10
`endif
`ifndef PORT_STAT_SIZE
`define PORT_STAT_SIZE 1
`endif
`ifndef ACTIVE
`define ACTIVE 1'b1
`endif
`ifndef INACTIVE
`define INACTIVE 1'b0
`endif

module pg_port_ctrl #(
    parameter int unsigned EPOCH_LEN     = 1024,
    parameter int unsigned PORT_LOAD_W   = `PG_PORT_LOAD_SIZE,
    parameter int unsigned ROUTER_LOAD_W = `PG_ROUTER_LOAD_SIZE,
    parameter int unsigned LOW_THRESH    = 16,
    parameter int unsigned HIGH_THRESH   = 64,
    parameter int unsigned ROUTER_THRESH = 128,
    parameter int unsigned MAX_OFF       = 2,
    parameter int unsigned DRAIN_CYC     = 4,
    parameter int unsigned WAKE_LAT      = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            pg_global_en_i,
    input  logic [4*PORT_LOAD_W-1:0]        port_load_i,
    input  logic [ROUTER_LOAD_W-1:0]        router_load_i,
    input  logic [3:0]                      link_idle_i,
    input  logic [3:0]                      wake_req_i,
    output logic                            pg_enable_o,
    output logic [4*`PORT_STAT_SIZE-1:0]    port_status_o,
    output logic [3:0]                      gate_req_o,
    output logic [3:0]                      power_off_o
);

    localparam int unsigned EpochW = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
    localparam int unsigned IdleW  = $clog2(DRAIN_CYC + 1);
    localparam int unsigned WakeW  = $clog2(WAKE_LAT + 1);
    localparam int unsigned StatW  = `PORT_STAT_SIZE;

    localparam logic [EpochW-1:0]        EpochLast  = EpochW'(EPOCH_LEN - 1);
    localparam logic [IdleW-1:0]         IdleLast   = IdleW'(DRAIN_CYC - 1);
    localparam logic [WakeW-1:0]         WakeLast   = WakeW'(WAKE_LAT - 1);
    localparam logic [PORT_LOAD_W-1:0]   LowTh      = PORT_LOAD_W'(LOW_THRESH);
    localparam logic [PORT_LOAD_W-1:0]   HighTh     = PORT_LOAD_W'(HIGH_THRESH);
    localparam logic [ROUTER_LOAD_W-1:0] RouterTh   = ROUTER_LOAD_W'(ROUTER_THRESH);
    localparam logic [2:0]               MaxOff     = 3'(MAX_OFF);
    localparam logic [StatW-1:0]         StatActive = StatW'(`ACTIVE);
    localparam logic [StatW-1:0]         StatOff    = StatW'(`INACTIVE);

    typedef enum logic [1:0] {StOn, StDrain, StOff, StWake} port_state_e;

    logic [EpochW-1:0]      epoch_q, epoch_d;
    logic                   pg_enable_q, pg_enable_d;
    port_state_e            state_q [4];
    port_state_e            state_d [4];
    logic [IdleW-1:0]       idle_q  [4];
    logic [IdleW-1:0]       idle_d  [4];
    logic [WakeW-1:0]       wake_q  [4];
    logic [WakeW-1:0]       wake_d  [4];
    logic [4*StatW-1:0]     status_q, status_d;
    logic [3:0]             gate_req_q, gate_req_d;
    logic [3:0]             power_off_q, power_off_d;

    logic [PORT_LOAD_W-1:0] load      [4];
    logic [3:0]             wake_cond;
    logic                   decision;
    logic                   router_ok;
    logic [2:0]             n_busy;

    // The registered pulse marks the decision cycle itself.
    assign decision  = pg_enable_q;
    assign router_ok = (router_load_i <= RouterTh);

    // Per-port load slice and the condition that aborts a drain or wakes a gated port.
    for (genvar g = 0; g < 4; g++) begin : g_port
        assign load[g]      = port_load_i[g*PORT_LOAD_W +: PORT_LOAD_W];
        assign wake_cond[g] = wake_req_i[g] || !pg_global_en_i ||
                              (decision && (load[g] >= HighTh));
    end

    // Epoch counter; pulse is registered so it is high while the counter sits at the last value.
    always_comb begin
        epoch_d     = (epoch_q == EpochLast) ? '0 : epoch_q + 1'b1;
        pg_enable_d = (epoch_d == EpochLast);
    end

    // Per-port next state: wake/abort first, then drain completion, then gating in index order.
    always_comb begin
        n_busy = '0;
        for (int i = 0; i < 4; i++) begin
            if (state_q[i] == StDrain || state_q[i] == StOff) begin
                n_busy = n_busy + 3'd1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            idle_d[i]  = idle_q[i];
            wake_d[i]  = wake_q[i];
            unique case (state_q[i])
                StOn: begin
                    if (decision && pg_global_en_i && router_ok && (load[i] <= LowTh) &&
                        (n_busy < MaxOff)) begin
                        state_d[i] = StDrain;
                        idle_d[i]  = '0;
                        n_busy     = n_busy + 3'd1;
                    end
                end
                StDrain: begin
                    if (wake_cond[i]) begin
                        state_d[i] = StOn;
                        idle_d[i]  = '0;
                    end else if (link_idle_i[i]) begin
                        if (idle_q[i] == IdleLast) begin
                            state_d[i] = StOff;
                            idle_d[i]  = '0;
                        end else begin
                            idle_d[i] = idle_q[i] + 1'b1;
                        end
                    end else begin
                        idle_d[i] = '0;
                    end
                end
                StOff: begin
                    if (wake_cond[i]) begin
                        state_d[i] = StWake;
                        wake_d[i]  = '0;
                    end
                end
                StWake: begin
                    if (wake_q[i] == WakeLast) begin
                        state_d[i] = StOn;
                        wake_d[i]  = '0;
                    end else begin
                        wake_d[i] = wake_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = StOn;
            endcase
        end
    end

    // Output decode from next state so every output comes straight from a flop.
    always_comb begin
        status_d    = '0;
        gate_req_d  = '0;
        power_off_d = '0;
        for (int i = 0; i < 4; i++) begin
            status_d[i*StatW +: StatW] = (state_d[i] == StOn || state_d[i] == StDrain) ?
                                         StatActive : StatOff;
            gate_req_d[i]  = (state_d[i] != StOn);
            power_off_d[i] = (state_d[i] == StOff);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epoch_q     <= '0;
            pg_enable_q <= 1'b0;
            status_q    <= {4{StatActive}};
            gate_req_q  <= '0;
            power_off_q <= '0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= StOn;
                idle_q[i]  <= '0;
                wake_q[i]  <= '0;
            end
        end else begin
            epoch_q     <= epoch_d;
            pg_enable_q <= pg_enable_d;
            status_q    <= status_d;
            gate_req_q  <= gate_req_d;
            power_off_q <= power_off_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                idle_q[i]  <= idle_d[i];
                wake_q[i]  <= wake_d[i];
            end
        end
    end

    assign pg_enable_o   = pg_enable_q;
    assign port_status_o = status_q;
    assign gate_req_o    = gate_req_q;
    assign power_off_o   = power_off_q;

endmodule

// File: tb/tb_pg_port_ctrl.sv
// Testbench for pg_port_ctrl: expected output values are queued with the cycle at
// which they must appear and are compared as the simulation reaches that cycle.

`ifndef PORT_STAT_SIZE
`define PORT_STAT_SIZE 1
`endif

module tb_pg_port_ctrl;

    localparam int SigPg = 0, SigStat = 1, SigGate = 2, SigPow = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pg_global_en = 1'b1;
    logic [31:0] port_load = '0;
    logic [9:0]  router_load = '0;
    logic [3:0]  link_idle = 4'b1111;
    logic [3:0]  wake_req = '0;
    logic        pg_enable;
    logic [4*`PORT_STAT_SIZE-1:0] port_status;
    logic [3:0]  gate_req;
    logic [3:0]  power_off;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         cyc;
        int         sig;
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    pg_port_ctrl #(
        .EPOCH_LEN    (1024),
        .PORT_LOAD_W  (8),
        .ROUTER_LOAD_W(10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pg_global_en_i(pg_global_en),
        .port_load_i   (port_load),
        .router_load_i (router_load),
        .link_idle_i   (link_idle),
        .wake_req_i    (wake_req),
        .pg_enable_o   (pg_enable),
        .port_status_o (port_status),
        .gate_req_o    (gate_req),
        .power_off_o   (power_off)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] observe(input int sig);
        case (sig)
            SigPg:   return {3'b000, pg_enable};
            SigStat: return port_status[3:0];
            SigGate: return gate_req;
            default: return power_off;
        endcase
    endfunction

    task automatic push(input int c, input int sig, input logic [3:0] e, input string n);
        exp_t x;
        x.cyc  = c;
        x.sig  = sig;
        x.exp  = e;
        x.name = n;
        sb.push_back(x);
    endtask

    // Step the clock, comparing every queued expectation that falls due.
    task automatic advance_to(input int t);
        logic [3:0] obs;
        while (cyc < t) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].cyc == cyc) begin
                    obs = observe(sb[k].sig);
                    n_tests++;
                    if (obs !== sb[k].exp) begin
                        n_fail++;
                        $display("FAIL %s @cycle %0d: got %b want %b", sb[k].name, cyc, obs,
                                 sb[k].exp);
                    end
                    sb.delete(k);
                end
            end
        end
    endtask

    task automatic do_reset(input logic [31:0] ld, input logic [9:0] rl);
        reset        = 1'b0;
        port_load    = ld;
        router_load  = rl;
        pg_global_en = 1'b1;
        link_idle    = 4'b1111;
        wake_req     = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        n_tests += 4;
        if (pg_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pg: got %b want 0", pg_enable);
        end
        if (port_status[3:0] !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_status: got %b want 1111", port_status[3:0]);
        end
        if (gate_req !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gate: got %b want 0000", gate_req);
        end
        if (power_off !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_power: got %b want 0000", power_off);
        end
        do_reset('0, '0);
        push(5, SigPg, 4'b0000, "early_pg");
        push(5, SigGate, 4'b0000, "early_gate");
        advance_to(5);
    endtask

    // Idle router, MAX_OFF limit, HIGH_THRESH-1 not waking, load wake and neighbour wake.
    task automatic test_idle_and_wake();
        do_reset('0, '0);
        push(1022, SigPg, 4'b0000, "pg_before");
        push(1023, SigPg, 4'b0001, "pg_first");
        push(1023, SigGate, 4'b0000, "gate_at_decision");
        push(1024, SigGate, 4'b0011, "idle_gate");
        push(1024, SigPg, 4'b0000, "pg_one_cycle");
        push(1024, SigPow, 4'b0000, "idle_pow_early");
        push(1027, SigPow, 4'b0000, "idle_pow_before");
        push(1028, SigPow, 4'b0011, "idle_pow");
        push(1028, SigStat, 4'b1100, "idle_status");
        advance_to(1030);
        port_load = {8'd0, 8'd0, 8'd0, 8'd63};
        push(2047, SigPg, 4'b0001, "pg_second");
        push(2048, SigGate, 4'b0011, "max_off_gate");
        push(2048, SigPow, 4'b0011, "load63_no_wake");
        advance_to(2100);
        port_load = {8'd0, 8'd0, 8'd0, 8'd64};
        push(3072, SigPow, 4'b0010, "load_wake_pow");
        push(3072, SigGate, 4'b0011, "load_wake_gate");
        push(3072, SigStat, 4'b1100, "load_wake_stat0");
        push(3079, SigStat, 4'b1100, "load_wake_stat7");
        push(3080, SigStat, 4'b1101, "load_wake_active");
        push(3080, SigGate, 4'b0010, "load_wake_gate_done");
        advance_to(3200);
        wake_req = 4'b0010;
        push(3201, SigPow, 4'b0000, "nbr_wake_pow");
        push(3201, SigStat, 4'b1101, "nbr_wake_stat0");
        push(3208, SigStat, 4'b1101, "nbr_wake_stat7");
        push(3209, SigStat, 4'b1111, "nbr_wake_active");
        push(3209, SigGate, 4'b0000, "nbr_wake_gate");
        advance_to(3201);
        wake_req = 4'b0000;
        advance_to(3210);
    endtask

    // Threshold boundaries, drain stall on E, then global disable with two ports off.
    task automatic test_drain_stall_and_disable();
        do_reset({8'd0, 8'd0, 8'd17, 8'd16}, 10'd128);
        push(1024, SigGate, 4'b0101, "thresh_gate");
        push(1028, SigPow, 4'b0100, "stall_pow");
        push(1040, SigPow, 4'b0100, "stall_pow_late");
        push(1040, SigGate, 4'b0101, "stall_gate_late");
        push(1040, SigStat, 4'b1011, "stall_status");
        advance_to(1024);
        for (int c = 1024; c <= 1040; c++) begin
            link_idle = {3'b111, ((c - 1024) % 3) != 2};
            advance_to(c + 1);
        end
        link_idle = 4'b1111;
        push(1050, SigPow, 4'b0101, "two_off");
        advance_to(1050);
        pg_global_en = 1'b0;
        push(1051, SigPow, 4'b0000, "dis_pow");
        push(1051, SigStat, 4'b1010, "dis_stat0");
        push(1051, SigGate, 4'b0101, "dis_gate");
        push(1058, SigStat, 4'b1010, "dis_stat7");
        push(1059, SigStat, 4'b1111, "dis_active");
        push(1059, SigGate, 4'b0000, "dis_gate_done");
        push(2047, SigPg, 4'b0001, "dis_pg_continues");
        push(2048, SigGate, 4'b0000, "dis_no_gating");
        advance_to(2050);
    endtask

    task automatic test_blocked();
        do_reset('0, 10'd129);
        push(1023, SigPg, 4'b0001, "blk_pg");
        push(1024, SigGate, 4'b0000, "blk_gate");
        push(1028, SigPow, 4'b0000, "blk_pow");
        advance_to(1030);
    endtask

    task automatic test_async_reset();
        do_reset('0, '0);
        push(1025, SigGate, 4'b0011, "pre_rst_gate");
        advance_to(1025);
        #2 reset = 1'b0;
        #1;
        n_tests += 3;
        if (gate_req !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_rst_gate: got %b want 0000", gate_req);
        end
        if (port_status[3:0] !== 4'b1111) begin
            n_fail++;
            $display("FAIL async_rst_status: got %b want 1111", port_status[3:0]);
        end
        if (pg_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_pg: got %b want 0", pg_enable);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        push(1022, SigPg, 4'b0000, "rst_epoch_restart");
        push(1024, SigGate, 4'b0011, "rst_regate");
        advance_to(1024);
    endtask

    initial begin
        test_reset();
        test_idle_and_wake();
        test_drain_stall_and_disable();
        test_blocked();
        test_async_reset();
        while (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked", sb[0].name, sb[0].cyc);
            sb.delete(0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
